// File: rtl/char_seq_pkg.sv
// Shared types for the character scan sequencer.
// State encoding, box record and box helpers.
package char_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      DWELL,
      DONE
   } seq_state_t;

   localparam logic [3:0] INVALID_DIGIT = 4'hF;

   typedef struct packed {
      logic [11:0] left;
      logic [11:0] right;
      logic [11:0] up;
      logic [11:0] down;
   } box_t;

   function automatic logic box_ok(input box_t b);
      return (b.right > b.left) && (b.down > b.up);
   endfunction

   function automatic logic [11:0] quarter_h(input box_t b);
      logic [11:0] h;
      h = b.down - b.up;
      return h >> 2;
   endfunction

endpackage

// File: rtl/char_box_regfile.sv
// Character box storage written by segmentation.
// Validity is judged once at write time.
module char_box_regfile
   import char_seq_pkg::*;
#(
   parameter int NUM = 7
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_idx,
   input  box_t       wr_box,
   input  logic [2:0] rd_idx,
   output box_t       rd_box,
   output logic       rd_valid
);

   localparam logic [3:0] NUM_W = 4'(NUM);

   box_t           mem [NUM];
   logic [NUM-1:0] vld;
   logic           wr_ok;
   logic           rd_ok;

   assign wr_ok = wr_en && ({1'b0, wr_idx} < NUM_W);
   assign rd_ok = {1'b0, rd_idx} < NUM_W;

   // Store box and its validity flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++) begin
            mem[i] <= '0;
         end
         vld <= '0;
      end else if (wr_ok) begin
         mem[wr_idx] <= wr_box;
         vld[wr_idx] <= box_ok(wr_box);
      end
   end

   // Read port; out-of-range slots look empty.
   always_comb begin
      rd_box   = '0;
      rd_valid = 1'b0;
      if (rd_ok) begin
         rd_box   = mem[rd_idx];
         rd_valid = vld[rd_idx];
      end
   end

endmodule

// File: rtl/char_scan_sequencer.sv
// Walks the digit scanner over each plate character box.
// Define SCAN_VOTE_EN for consecutive-match digit voting.
module char_scan_sequencer
   import char_seq_pkg::*;
#(
   parameter int NUM_CHARS     = 7,
   parameter int FIRST_IDX     = 2,
   parameter int SETTLE_FRAMES = 2
`ifdef SCAN_VOTE_EN
   ,
   parameter int MAX_TRIES     = 4
`endif
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_vs,
   input  logic                   start,
   input  logic                   seg_wr,
   input  logic [2:0]             seg_idx,
   input  logic [11:0]            seg_left,
   input  logic [11:0]            seg_right,
   input  logic [11:0]            seg_up,
   input  logic [11:0]            seg_down,
   input  logic [3:0]             i_digit,
   output logic [11:0]            char_left,
   output logic [11:0]            char_right,
   output logic [11:0]            char_up,
   output logic [11:0]            char_down,
   output logic [11:0]            row_scanf_line1,
   output logic [11:0]            row_scanf_line2,
   output logic [2:0]             cur_idx,
   output logic                   busy,
   output logic [4*NUM_CHARS-1:0] plate_digits,
   output logic                   plate_valid
);

   localparam int         PW       = 4 * NUM_CHARS;
   localparam logic [2:0] FIRST_I  = 3'(FIRST_IDX);
   localparam logic [2:0] LAST_I   = 3'(NUM_CHARS - 1);
   localparam logic [3:0] SET_LAST = 4'(SETTLE_FRAMES - 1);

   seq_state_t    state, state_n;
   logic [2:0]    idx, idx_n, nidx, rd_idx;
   logic [3:0]    fcnt, fcnt_n;
   logic [PW-1:0] shadow, shadow_n, pd_n;
   box_t          box_q, box_n, rd_box, seg_box;
   logic          rd_valid;
   logic [11:0]   l1_q, l1_n, l2_q, l2_n, qh;
   logic          pv_n, vs_d, vf, load;
   logic          slot_done;
   logic [3:0]    slot_val;

`ifdef SCAN_VOTE_EN
   localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

   logic [3:0] prev_q, prev_n;
   logic [3:0] tries_q, tries_n;
   logic       hp_q, hp_n;
`endif

   assign seg_box = '{seg_left, seg_right, seg_up, seg_down};
   assign vf      = vs_d & ~i_vs;
   assign nidx    = idx + 3'd1;
   assign rd_idx  = (state == DWELL) ? nidx : idx;
   assign qh      = quarter_h(rd_box);

   assign char_left       = box_q.left;
   assign char_right      = box_q.right;
   assign char_up         = box_q.up;
   assign char_down       = box_q.down;
   assign row_scanf_line1 = l1_q;
   assign row_scanf_line2 = l2_q;
   assign cur_idx         = idx;

   char_box_regfile #(
      .NUM (NUM_CHARS)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (seg_wr & ~busy),
      .wr_idx   (seg_idx),
      .wr_box   (seg_box),
      .rd_idx   (rd_idx),
      .rd_box   (rd_box),
      .rd_valid (rd_valid)
   );

   // Decide this cycle's capture and vote outcome.
   always_comb begin
      slot_done = 1'b0;
      slot_val  = INVALID_DIGIT;
`ifdef SCAN_VOTE_EN
      prev_n    = prev_q;
      hp_n      = hp_q;
      tries_n   = tries_q;
      if (state == DWELL && vf && fcnt == SET_LAST) begin
         if (hp_q && i_digit == prev_q) begin
            slot_done = 1'b1;
            slot_val  = i_digit;
         end else if (tries_q == TRY_LAST) begin
            slot_done = 1'b1;
         end else begin
            prev_n  = i_digit;
            hp_n    = 1'b1;
            tries_n = tries_q + 4'd1;
         end
      end
      if (load) begin
         prev_n  = 4'h0;
         hp_n    = 1'b0;
         tries_n = 4'h0;
      end
`else
      if (state == DWELL && vf && fcnt == SET_LAST) begin
         slot_done = 1'b1;
         slot_val  = i_digit;
      end
`endif
   end

   // Next state, slot bookkeeping and box loads.
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      fcnt_n   = fcnt;
      shadow_n = shadow;
      pd_n     = plate_digits;
      pv_n     = 1'b0;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               idx_n = FIRST_I;
               for (int k = 0; k < FIRST_IDX; k++) begin
                  shadow_n[4*k +: 4] = INVALID_DIGIT;
               end
               state_n = ARM;
            end
         end
         ARM: begin
            if (vf) begin
               if (rd_valid) begin
                  load    = 1'b1;
                  fcnt_n  = 4'd0;
                  state_n = DWELL;
               end else begin
                  shadow_n[{idx, 2'b00} +: 4] = INVALID_DIGIT;
                  if (idx == LAST_I) begin
                     state_n = DONE;
                  end else begin
                     idx_n = nidx;
                  end
               end
            end
         end
         DWELL: begin
            if (vf && fcnt != SET_LAST) begin
               fcnt_n = fcnt + 4'd1;
            end
            if (slot_done) begin
               shadow_n[{idx, 2'b00} +: 4] = slot_val;
               if (idx == LAST_I) begin
                  state_n = DONE;
               end else begin
                  idx_n  = nidx;
                  fcnt_n = 4'd0;
                  if (rd_valid) begin
                     load = 1'b1;
                  end else begin
                     shadow_n[{nidx, 2'b00} +: 4] = INVALID_DIGIT;
                     if (nidx == LAST_I) begin
                        state_n = DONE;
                     end else begin
                        idx_n   = idx + 3'd2;
                        state_n = ARM;
                     end
                  end
               end
            end
         end
         DONE: begin
            pd_n    = shadow;
            pv_n    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Box and row-line outputs only move on a loading frame boundary.
   always_comb begin
      box_n = box_q;
      l1_n  = l1_q;
      l2_n  = l2_q;
      if (load) begin
         box_n = rd_box;
         l1_n  = rd_box.up + qh;
         l2_n  = rd_box.down - qh;
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= 3'd0;
         fcnt         <= 4'd0;
         shadow       <= {NUM_CHARS{INVALID_DIGIT}};
         plate_digits <= {NUM_CHARS{INVALID_DIGIT}};
         plate_valid  <= 1'b0;
         busy         <= 1'b0;
         vs_d         <= 1'b0;
         box_q        <= '0;
         l1_q         <= 12'd0;
         l2_q         <= 12'd0;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         fcnt         <= fcnt_n;
         shadow       <= shadow_n;
         plate_digits <= pd_n;
         plate_valid  <= pv_n;
         busy         <= (state_n != IDLE);
         vs_d         <= i_vs;
         box_q        <= box_n;
         l1_q         <= l1_n;
         l2_q         <= l2_n;
      end
   end

`ifdef SCAN_VOTE_EN
   // Vote tracking for the slot being scanned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= 4'h0;
         hp_q    <= 1'b0;
         tries_q <= 4'h0;
      end else begin
         prev_q  <= prev_n;
         hp_q    <= hp_n;
         tries_q <= tries_n;
      end
   end
`endif

endmodule

// File: tb/tb_char_scan_sequencer.sv
// Scoreboard bench for char_scan_sequencer.
// Frames are 6 cycles of i_vs high then 2 low (one vf each).
module tb_char_scan_sequencer;

   logic        clk;
   logic        rst_n;
   logic        i_vs;
   logic        start;
   logic        seg_wr;
   logic [2:0]  seg_idx;
   logic [11:0] seg_left, seg_right, seg_up, seg_down;
   logic [3:0]  i_digit;
   logic [11:0] char_left, char_right, char_up, char_down;
   logic [11:0] row_scanf_line1, row_scanf_line2;
   logic [2:0]  cur_idx;
   logic        busy;
   logic [27:0] plate_digits;
   logic        plate_valid;

   char_scan_sequencer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_vs            (i_vs),
      .start           (start),
      .seg_wr          (seg_wr),
      .seg_idx         (seg_idx),
      .seg_left        (seg_left),
      .seg_right       (seg_right),
      .seg_up          (seg_up),
      .seg_down        (seg_down),
      .i_digit         (i_digit),
      .char_left       (char_left),
      .char_right      (char_right),
      .char_up         (char_up),
      .char_down       (char_down),
      .row_scanf_line1 (row_scanf_line1),
      .row_scanf_line2 (row_scanf_line2),
      .cur_idx         (cur_idx),
      .busy            (busy),
      .plate_digits    (plate_digits),
      .plate_valid     (plate_valid)
   );

   typedef struct {
      logic [27:0] d;
      int          nvf;
   } exp_t;

   exp_t sbq[$];
   int   vectors;
   int   miscompares;

   logic [71:0] box_now;
   logic [71:0] m_box_prev;
   logic        m_vs_prev;
   logic        m_rst_prev;
   logic        m_scan;
   logic        vfd;
   int          m_nvf;
   int          m_since;

   assign box_now = {char_left, char_right, char_up, char_down,
                     row_scanf_line1, row_scanf_line2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: own vf model, box-change timing and plate scoreboard.
   initial begin
      m_vs_prev  = 1'b0;
      m_rst_prev = 1'b0;
      m_scan     = 1'b0;
      m_nvf      = 0;
      m_since    = 0;
      m_box_prev = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_vs_prev  = 1'b0;
            m_rst_prev = 1'b0;
            m_scan     = 1'b0;
            m_box_prev = box_now;
         end else begin
            vfd       = m_vs_prev && !i_vs;
            m_vs_prev = i_vs;
            if (start && !m_scan) begin
               m_scan = 1'b1;
               m_nvf  = 0;
            end else if (vfd) begin
               m_nvf++;
            end
            if (vfd) m_since = 0;
            else m_since++;
            if (m_rst_prev && box_now != m_box_prev) begin
               vectors++;
               if (!vfd) begin
                  miscompares++;
                  $display("FAIL box_timing: outputs moved off a vf, %0h -> %0h",
                           m_box_prev, box_now);
               end
            end
            m_box_prev = box_now;
            m_rst_prev = 1'b1;
            if (plate_valid) begin
               vectors++;
               if (sbq.size() == 0) begin
                  miscompares++;
                  $display("FAIL plate_unexpected: got %h, expected no plate_valid",
                           plate_digits);
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  if (plate_digits !== e.d || m_nvf != e.nvf || m_since != 1) begin
                     miscompares++;
                     $display("FAIL plate: got %h vf=%0d lag=%0d, expected %h vf=%0d lag=1",
                              plate_digits, m_nvf, m_since, e.d, e.nvf);
                  end
               end
               m_scan = 1'b0;
            end
         end
      end
   end

   task automatic wb(input logic [2:0] k, input logic [11:0] l,
                     input logic [11:0] r, input logic [11:0] u,
                     input logic [11:0] d);
      seg_wr    = 1'b1;
      seg_idx   = k;
      seg_left  = l;
      seg_right = r;
      seg_up    = u;
      seg_down  = d;
      @(negedge clk);
      seg_wr = 1'b0;
   endtask

   // Slot k box: left 10+40k, width 30, rows 100..180; slot 3 rows 50..93.
   task automatic load_boxes();
      for (int k = 2; k < 7; k++) begin
         if (k == 3) wb(3'(k), 12'(10 + 40*k), 12'(40 + 40*k), 12'd50, 12'd93);
         else wb(3'(k), 12'(10 + 40*k), 12'(40 + 40*k), 12'd100, 12'd180);
      end
   endtask

   task automatic do_frame(input logic [3:0] d, input bit st);
      i_digit = d;
      i_vs    = 1'b1;
      repeat (6) @(negedge clk);
      i_vs = 1'b0;
      if (st) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   // Digits listed left-to-right in frame order.
   task automatic run_frames(input logic [79:0] ds, input int n);
      for (int i = 0; i < n; i++) begin
         do_frame(ds[4*(n-1-i) +: 4], 1'b0);
      end
   endtask

   task automatic start_scan();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", 32'(busy), 32'd1);
   endtask

   task automatic push(input logic [27:0] d, input int n);
      exp_t e;
      e.d   = d;
      e.nvf = n;
      sbq.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n   = 1'b0;
      i_vs    = 1'b0;
      start   = 1'b0;
      seg_wr  = 1'b0;
      seg_idx = 3'd0;
      seg_left = 12'd0; seg_right = 12'd0;
      seg_up   = 12'd0; seg_down  = 12'd0;
      i_digit = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_char_left", 32'(char_left), 32'd0);
      chk("rst_char_down", 32'(char_down), 32'd0);
      chk("rst_line1", 32'(row_scanf_line1), 32'd0);
      chk("rst_line2", 32'(row_scanf_line2), 32'd0);
      chk("rst_cur_idx", 32'(cur_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_plate", 32'(plate_digits), 32'h0FFFFFFF);
      chk("rst_valid", 32'(plate_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_frames(12'hAAA, 3);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_plate", 32'(plate_digits), 32'h0FFFFFFF);

      load_boxes();
`ifdef SCAN_VOTE_EN
      push(28'h6547FFF, 18);
      start_scan();
      run_frames(36'hAA3535A77, 9);
      chk("vote_idx", 32'(cur_idx), 32'd4);
      run_frames(36'hA44A55A66, 9);
      wait_drain();
`else
      // All five boxes valid, digit = slot number on capture frames.
      push(28'h65432FF, 11);
      start_scan();
      run_frames(4'hA, 1);
      chk("l1_slot2", 32'(row_scanf_line1), 32'd120);
      chk("l2_slot2", 32'(row_scanf_line2), 32'd160);
      chk("up_slot2", 32'(char_up), 32'd100);
      chk("idx_slot2", 32'(cur_idx), 32'd2);
      run_frames(8'hA2, 2);
      chk("l1_slot3", 32'(row_scanf_line1), 32'd60);
      chk("l2_slot3", 32'(row_scanf_line2), 32'd83);
      chk("idx_slot3", 32'(cur_idx), 32'd3);
      run_frames(32'hA3A4A5A6, 8);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_plate", 32'(plate_digits), 32'h065432FF);
      wait_drain();

      // Slot 4 degenerate; start lands on a vf and must not arm there.
      wb(3'd4, 12'd170, 12'd170, 12'd100, 12'd180);
      push(28'h65F32FF, 10);
      do_frame(4'hA, 1'b1);
      run_frames(20'hAA2A3, 5);
      chk("skip_idx", 32'(cur_idx), 32'd5);
      chk("skip_hold", 32'(char_left), 32'd130);
      run_frames(4'hA, 1);
      chk("skip_load5", 32'(char_left), 32'd210);
      run_frames(16'hA5A6, 4);
      wait_drain();

      // Reset during slot 4 dwell, then full rescan.
      load_boxes();
      start_scan();
      run_frames(20'hAA2A3, 5);
      chk("pre_rst_idx", 32'(cur_idx), 32'd4);
      i_vs = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_plate", 32'(plate_digits), 32'h0FFFFFFF);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_idx", 32'(cur_idx), 32'd0);
      chk("mid_rst_line1", 32'(row_scanf_line1), 32'd0);
      rst_n = 1'b1;
      i_vs  = 1'b0;
      @(negedge clk);
      load_boxes();
      push(28'h65432FF, 11);
      start_scan();
      run_frames(8'hAA, 2);
      start_scan();
      wb(3'd6, 12'd500, 12'd400, 12'd10, 12'd20);
      run_frames(32'h2A3A4A5A, 8);
      chk("rescan_partial", 32'(plate_digits), 32'h0FFFFFFF);
      run_frames(4'h6, 1);
      wait_drain();
`endif
      run_frames(8'hAA, 2);
      chk("final_queue", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/char_scan_sequencer.md
# char_scan_sequencer

Sequences the single-character digit feature scanner across all character boxes of a detected licence plate. It presents one character bounding box at a time, along with the two derived row-scan lines, and holds it for a whole number of frames. After the dwell it captures the scanner's 4-bit digit into a per-position result slot. When every slot is filled it emits the assembled plate code with a one-cycle valid pulse. It sits between the character-segmentation stage, which writes the boxes, and the feature scanner plus the OSD/readout logic.

## Interface
- NUM_CHARS, 7: character slots per plate
- FIRST_IDX, 2: first slot scanned; lower slots (province/letter) are forced to INVALID_DIGIT
- SETTLE_FRAMES, 2: frame boundaries between box load and first digit capture, range 1..15
- MAX_TRIES, 4: captures per slot in vote mode, range 2..15
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_vs  in  1  frame-active sync, high during the active frame; a falling edge is a frame boundary
- start  in  1  one-cycle pulse that begins a plate scan
- seg_wr  in  1  box write strobe
- seg_idx  in  3  box slot written
- seg_left, seg_right, seg_up, seg_down  in  12 each  box edges
- i_digit  in  4  scanner digit result
- char_left, char_right, char_up, char_down  out  12 each  box driven to scanner
- row_scanf_line1, row_scanf_line2  out  12 each  row-scan lines driven to scanner
- cur_idx  out  3  slot currently presented
- busy  out  1  scan in progress
- plate_digits  out  4*NUM_CHARS  slot k in bits [4k+3:4k]
- plate_valid  out  1  one-cycle pulse when plate_digits is updated

## Operation
- Box register file: NUM_CHARS entries. Each seg_wr writes one entry. Writes are ignored while busy=1, and writes with seg_idx >= NUM_CHARS are ignored.
- Box validity: a box is valid iff right > left and down > up.
- Row-scan lines, 12-bit arithmetic with h = down - up:
  - line1 = up + (h>>2)
  - line2 = down - (h>>2)
- Frame boundary: vf = registered i_vs delayed by one cycle ANDed with !i_vs. The delay register resets to 0.
- FSM states: IDLE, ARM, DWELL, DONE.
  - IDLE: busy=0. On start, set idx=FIRST_IDX, write INVALID_DIGIT into slots below FIRST_IDX in a shadow result, then go to ARM. start is ignored in every other state.
  - ARM: wait for vf.
    - At vf, if box[idx] is valid: load the output box and line registers from box[idx], clear fcnt, go to DWELL.
    - At vf, if box[idx] is invalid: write INVALID_DIGIT to slot idx and increment idx. Go to DONE if idx was NUM_CHARS-1, otherwise stay in ARM (a skipped slot costs one frame).
  - DWELL: fcnt increments on each vf. When vf arrives with fcnt == SETTLE_FRAMES-1, capture i_digit into shadow slot idx in that same cycle.
    - If idx == NUM_CHARS-1, go to DONE.
    - Otherwise increment idx and, in that same vf cycle, load box[idx+1] and clear fcnt. Stay in DWELL if the next box is valid; if it is invalid, write INVALID_DIGIT and continue as in ARM.
  - DONE: copy the shadow result to plate_digits, pulse plate_valid, go to IDLE.
- Box outputs change only in a vf cycle, never mid-frame, and hold their value in IDLE.
- Reset mid-scan: all state returns to reset values. A partial plate is never published.

## Timing
- Reset values:
  - all box and line outputs: 0
  - cur_idx: 0
  - busy: 0
  - plate_digits: {NUM_CHARS{4'hF}}
  - plate_valid: 0
- Outputs are registered. A box is visible one cycle after its vf cycle.
- busy rises the cycle after start is sampled and falls the cycle after DONE.
- Latency with all boxes valid and voting off: (NUM_CHARS-FIRST_IDX)*SETTLE_FRAMES frame boundaries after the arming vf, plus 2 cycles to plate_valid.
- vf in the same cycle as start: not acted on. The scan arms on the next vf.

## Configuration
- SCAN_VOTE_EN defined: after the settle period, i_digit is captured on every vf, up to MAX_TRIES captures.
  - A slot is accepted when two consecutive captures are equal.
  - If MAX_TRIES captures pass with no consecutive match, the slot gets INVALID_DIGIT.
  - The tracking registers for the previous capture and the try count are cleared on each box load.
- SCAN_VOTE_EN undefined: a single capture at the end of the settle period. MAX_TRIES is unused.

## Structure
- Package char_seq_pkg holds:
  - the state enum (IDLE, ARM, DWELL, DONE)
  - INVALID_DIGIT = 4'hF
  - the box struct {left, right, up, down}
- One sub-module, char_box_regfile: write port, combinational read port, and a per-entry valid flag.

## Test plan
- Reset with no start -> all outputs at reset values; plate_valid is never asserted.
- Boxes 2..6 valid, SETTLE_FRAMES=2, i_digit held at slot number -> plate_valid after 10 vf; plate_digits = {6,5,4,3,2,F,F}.
- Slot 4 written with right == left -> that slot reads F; box outputs skip it; total is 9 vf.
- Box up=100, down=180 -> line1=120, line2=160 appear one cycle after the loading vf; no change mid-frame.
- SCAN_VOTE_EN, i_digit toggling 3,5,3,5 on slot 2 -> slot 2 = F; a sequence 7,7 on slot 3 -> slot 3 = 7 after 2 post-settle captures.
- rst_n low during DWELL of slot 4, then a new start -> plate_digits stays all F until the full rescan completes; start pulses while busy are ignored.
